// File: rtl/core_pc_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// core_pc_ctrl_pkg
// Shared types and constants for the xRV32I program-counter / fetch-control
// stage.
//   - instruction address/data widths and their typedefs
//   - reset address and the hold/jump request encodings
//   - FSM state encoding for core_pc_ctrl
//   - helpers for PC stepping and word alignment
// -----------------------------------------------------------------------------
package core_pc_ctrl_pkg;

   localparam int INST_ADDR_W = 32;   // instruction address bus width
   localparam int INST_W      = 32;   // instruction word width

   typedef logic [INST_ADDR_W-1:0] inst_addr_t;
   typedef logic [INST_W-1:0]      inst_t;

   localparam inst_addr_t CPU_RST_ADDRESS = 32'h0000_0000;

   localparam logic HOLD_ENABLE  = 1'b1;
   localparam logic HOLD_NONE    = 1'b0;
   localparam logic JUMP_ENABLE  = 1'b1;
   localparam logic JUMP_DISABLE = 1'b0;

   localparam inst_addr_t INST_STEP = 32'd4;

   typedef enum logic [1:0] {
      PC_STATE_BOOT    = 2'd0,
      PC_STATE_FETCH   = 2'd1,
      PC_STATE_HOLD    = 2'd2,
      PC_STATE_DISCARD = 2'd3
   } pc_state_e;

   // Sequential PC step; wraps modulo 2^32 by construction.
   function automatic inst_addr_t pc_next(input inst_addr_t pc);
      return pc + INST_STEP;
   endfunction

   // Drop the byte offset so the address points at a whole instruction.
   function automatic inst_addr_t word_align(input inst_addr_t addr);
      return addr & ~inst_addr_t'(3);
   endfunction

endpackage

// File: rtl/core_pc_ctrl_if.sv
// -----------------------------------------------------------------------------
// core_pc_ctrl_if
// Instruction-fetch req/ack bus between the PC/fetch stage and instruction
// memory.
//   ifetch_req_out   fetch request         (master -> slave)
//   ifetch_addr_out  fetch address         (master -> slave)
//   ifetch_ack_in    fetch data valid      (slave  -> master)
//   ifetch_data_in   fetched instruction   (slave  -> master)
// The address is held stable by the master until the slave acknowledges.
// -----------------------------------------------------------------------------
interface core_pc_ctrl_if import core_pc_ctrl_pkg::*; ();

   logic       ifetch_req_out;
   inst_addr_t ifetch_addr_out;
   logic       ifetch_ack_in;
   inst_t      ifetch_data_in;

   modport master (
      output ifetch_req_out,
      output ifetch_addr_out,
      input  ifetch_ack_in,
      input  ifetch_data_in
   );

   modport slave (
      input  ifetch_req_out,
      input  ifetch_addr_out,
      output ifetch_ack_in,
      output ifetch_data_in
   );

endinterface

// File: rtl/core_pc_skid.sv
// -----------------------------------------------------------------------------
// core_pc_skid
// One-entry instruction + address buffer. Catches an instruction that
// completes while the front end is held so it can be handed on when the hold
// releases.
//   clk, rst    clock, asynchronous active-low reset
//   load        capture load_inst/load_addr, mark full
//   drain       entry consumed, mark empty
//   clear       discard the entry (wrong path), highest priority
//   full        entry valid
//   inst, addr  buffered instruction and its address
// Only the occupancy flag is reset; the payload is qualified by full.
// -----------------------------------------------------------------------------
module core_pc_skid import core_pc_ctrl_pkg::*; (
   input  logic       clk,
   input  logic       rst,
   input  logic       load,
   input  logic       drain,
   input  logic       clear,
   input  inst_t      load_inst,
   input  inst_addr_t load_addr,
   output logic       full,
   output inst_t      inst,
   output inst_addr_t addr
);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         full <= 1'b0;
      end else if (clear) begin
         full <= 1'b0;
      end else if (load) begin
         full <= 1'b1;
      end else if (drain) begin
         full <= 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (load) begin
         inst <= load_inst;
         addr <= load_addr;
      end
   end

endmodule

// File: rtl/core_pc_ctrl.sv
// -----------------------------------------------------------------------------
// core_pc_ctrl
// Program counter and instruction-fetch control at the front of the xRV32I
// pipeline. Owns the PC, issues fetches over a req/ack bus, applies hold and
// jump requests from execute, presents fetched instructions to IF/ID and
// drives the IF/ID + ID/EX flush/stall controls.
//
// Parameters
//   RESET_ADDR  PC after reset
//   TRAP_ADDR   redirect target for a misaligned jump (trap build only)
// Ports
//   clk, rst           clock, asynchronous active-low reset
//   hold_flag_ex_in    hold request from execute
//   jump_flag_ex_in    jump request from execute
//   jump_addr_ex_in    jump target from execute
//   hold_flag_ext_in   hold request from bus/debug
//   ifetch             fetch bus (master side of core_pc_ctrl_if)
//   inst_valid_out     instruction valid to IF/ID
//   inst_out           instruction
//   inst_addr_out      instruction address
//   flush_out          kill IF/ID and ID/EX (combinational)
//   stall_out          freeze IF/ID and ID/EX (combinational)
//   misalign_out       one-cycle misaligned-jump pulse
//
// Build option
//   CORE_PC_CTRL_MISALIGN_TRAP_EN  defined: a jump whose target has a byte
//   offset redirects to TRAP_ADDR and pulses misalign_out. Undefined: the
//   target is word-aligned and misalign_out stays 0.
// -----------------------------------------------------------------------------
module core_pc_ctrl import core_pc_ctrl_pkg::*; #(
   parameter inst_addr_t RESET_ADDR = CPU_RST_ADDRESS,
   parameter inst_addr_t TRAP_ADDR  = 32'h0000_0100
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           hold_flag_ex_in,
   input  logic           jump_flag_ex_in,
   input  inst_addr_t     jump_addr_ex_in,
   input  logic           hold_flag_ext_in,
   core_pc_ctrl_if.master ifetch,
   output logic           inst_valid_out,
   output inst_t          inst_out,
   output inst_addr_t     inst_addr_out,
   output logic           flush_out,
   output logic           stall_out,
   output logic           misalign_out
);

`ifdef CORE_PC_CTRL_MISALIGN_TRAP_EN
   localparam logic TRAP_EN = 1'b1;
`else
   localparam logic TRAP_EN = 1'b0;
`endif

   pc_state_e  state;
   inst_addr_t pc;
   logic       req_q;
   inst_addr_t addr_q;
   logic       valid_q;
   inst_t      inst_q;
   inst_addr_t inst_addr_q;
   logic       misalign_q;

   logic       hold_req;
   logic       jump_req;
   logic       fetch_done;
   logic       jump_misalign;
   inst_addr_t jump_target;

   logic       skid_load;
   logic       skid_drain;
   logic       skid_clear;
   logic       skid_full;
   inst_t      skid_inst;
   inst_addr_t skid_addr;

   assign hold_req   = (hold_flag_ex_in | hold_flag_ext_in) != HOLD_NONE;
   assign jump_req   = (jump_flag_ex_in == JUMP_ENABLE);
   assign fetch_done = req_q & ifetch.ifetch_ack_in;

   // A jump always wins over a hold, so the stall is suppressed while the
   // flush is active.
   assign flush_out = jump_req;
   assign stall_out = hold_req & (jump_flag_ex_in == JUMP_DISABLE);

   assign jump_misalign = (jump_addr_ex_in[1:0] != 2'b00);
   assign jump_target   = (TRAP_EN && jump_misalign) ? TRAP_ADDR
                                                     : word_align(jump_addr_ex_in);

   // The skid only ever catches a fetch that lands while held; a jump makes
   // whatever it holds wrong-path.
   assign skid_load  = ((state == PC_STATE_FETCH) || (state == PC_STATE_HOLD))
                       && !jump_req && hold_req && fetch_done;
   assign skid_drain = (state == PC_STATE_HOLD) && !jump_req && !hold_req
                       && skid_full;
   assign skid_clear = jump_req;

   core_pc_skid u_skid (
      .clk       (clk),
      .rst       (rst),
      .load      (skid_load),
      .drain     (skid_drain),
      .clear     (skid_clear),
      .load_inst (ifetch.ifetch_data_in),
      .load_addr (addr_q),
      .full      (skid_full),
      .inst      (skid_inst),
      .addr      (skid_addr)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state       <= PC_STATE_BOOT;
         pc          <= RESET_ADDR;
         req_q       <= 1'b0;
         addr_q      <= RESET_ADDR;
         valid_q     <= 1'b0;
         inst_q      <= '0;
         inst_addr_q <= '0;
         misalign_q  <= 1'b0;
      end else begin
         misalign_q <= 1'b0;
         if (jump_req) begin
            valid_q    <= 1'b0;
            pc         <= jump_target;
            misalign_q <= TRAP_EN & jump_misalign;
            if (state == PC_STATE_DISCARD) begin
               // Still waiting out the old fetch; only the target moves.
               if (ifetch.ifetch_ack_in) begin
                  state  <= PC_STATE_FETCH;
                  req_q  <= 1'b1;
                  addr_q <= jump_target;
               end
            end else if (req_q && !ifetch.ifetch_ack_in) begin
               // The memory still owes data for the old address; keep the
               // request and address stable and drop that data when it comes.
               state <= PC_STATE_DISCARD;
            end else begin
               // Any data acked this cycle is wrong-path and simply ignored.
               state  <= PC_STATE_FETCH;
               req_q  <= 1'b1;
               addr_q <= jump_target;
            end
         end else begin
            case (state)
               PC_STATE_BOOT: begin
                  state   <= PC_STATE_FETCH;
                  req_q   <= 1'b1;
                  addr_q  <= pc;
                  valid_q <= 1'b0;
               end

               PC_STATE_FETCH, PC_STATE_HOLD: begin
                  if (hold_req) begin
                     // No new request; an outstanding one is allowed to finish
                     // and its data parks in the skid buffer.
                     state   <= PC_STATE_HOLD;
                     valid_q <= 1'b0;
                     if (fetch_done) begin
                        req_q <= 1'b0;
                        pc    <= pc_next(pc);
                     end
                  end else if ((state == PC_STATE_HOLD) && skid_full) begin
                     state       <= PC_STATE_FETCH;
                     valid_q     <= 1'b1;
                     inst_q      <= skid_inst;
                     inst_addr_q <= skid_addr;
                     req_q       <= 1'b1;
                     addr_q      <= pc;
                  end else if (fetch_done) begin
                     state       <= PC_STATE_FETCH;
                     valid_q     <= 1'b1;
                     inst_q      <= ifetch.ifetch_data_in;
                     inst_addr_q <= addr_q;
                     pc          <= pc_next(pc);
                     req_q       <= 1'b1;
                     addr_q      <= pc_next(pc);
                  end else begin
                     state   <= PC_STATE_FETCH;
                     valid_q <= 1'b0;
                     req_q   <= 1'b1;
                     if (!req_q) begin
                        addr_q <= pc;
                     end
                  end
               end

               PC_STATE_DISCARD: begin
                  valid_q <= 1'b0;
                  if (ifetch.ifetch_ack_in) begin
                     if (hold_req) begin
                        state <= PC_STATE_HOLD;
                        req_q <= 1'b0;
                     end else begin
                        state  <= PC_STATE_FETCH;
                        req_q  <= 1'b1;
                        addr_q <= pc;
                     end
                  end
               end

               default: begin
                  state <= PC_STATE_BOOT;
                  req_q <= 1'b0;
               end
            endcase
         end
      end
   end

   assign ifetch.ifetch_req_out  = req_q;
   assign ifetch.ifetch_addr_out = addr_q;
   assign inst_valid_out         = valid_q;
   assign inst_out               = inst_q;
   assign inst_addr_out          = inst_addr_q;
   assign misalign_out           = TRAP_EN ? misalign_q : 1'b0;

endmodule

// File: doc/core_pc_ctrl.md
# core_pc_ctrl

Program-counter and fetch-control stage at the front of the xRV32I pipeline. It owns the PC and issues instruction-fetch requests to instruction memory over a req/ack handshake. It applies the hold and jump requests produced by the execute stage, and presents fetched instructions with their addresses to the IF/ID pipeline register. It also generates the pipeline flush and stall signals consumed by the IF/ID and ID/EX registers.

## Interface
- `RESET_ADDR`, default `CPURstAddress` (32'h0): PC value after reset.
- `TRAP_ADDR`, default 32'h0000_0100: redirect target for a misaligned jump (used only with the macro).
- `clk`  in  1  core clock; all state updates on the rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `hold_flag_ex_in`  in  1  hold request from execute.
- `jump_flag_ex_in`  in  1  jump request from execute.
- `jump_addr_ex_in`  in  32  jump target from execute.
- `hold_flag_ext_in`  in  1  hold request from bus/debug.
- `ifetch_req_out`  out  1  fetch request.
- `ifetch_addr_out`  out  32  fetch address.
- `ifetch_ack_in`  in  1  fetch data valid.
- `ifetch_data_in`  in  32  fetched instruction.
- `inst_valid_out`  out  1  instruction valid to IF/ID.
- `inst_out`  out  32  instruction.
- `inst_addr_out`  out  32  instruction address.
- `flush_out`  out  1  kill IF/ID and ID/EX contents.
- `stall_out`  out  1  freeze IF/ID and ID/EX.
- `misalign_out`  out  1  misaligned-jump pulse.

## Operation
- States: BOOT, FETCH, HOLD, DISCARD.
- Reset values:
  - pc = RESET_ADDR; state = BOOT.
  - All outputs 0, except `ifetch_addr_out` = RESET_ADDR.
  - Skid buffer empty.
- BOOT: no request. Moves to FETCH on the next edge. Any `ifetch_ack_in` is ignored.
- FETCH:
  - `ifetch_req_out` = 1 and `ifetch_addr_out` = pc.
  - Address is held stable until ack.
  - On ack: data and pc are registered into `inst_out`/`inst_addr_out`, `inst_valid_out` is set, and pc <= pc+4.
  - No ack: `inst_valid_out` = 0.
- Hold (`hold_flag_ex_in | hold_flag_ext_in`, no jump):
  - `stall_out` = 1 combinationally; enter HOLD.
  - No new request is issued. A request already outstanding completes.
  - Data acked during the hold goes to a one-entry skid buffer; `inst_valid_out` = 0 while in HOLD.
  - On release, the buffer drains to the inst outputs at the release edge, and the request is reasserted in the same cycle.
- Jump (`jump_flag_ex_in`):
  - Highest priority; overrides hold and clears the skid buffer.
  - `flush_out` = `jump_flag_ex_in` combinationally, in the same cycle.
  - pc <= target; `inst_valid_out` <= 0.
  - If a request is outstanding with no ack that cycle, enter DISCARD; otherwise enter FETCH.
- DISCARD: `ifetch_req_out` stays 1 with the old address until ack. The acked data is dropped, then the state moves to FETCH at the new pc. A further jump in DISCARD only updates the pc target.
- Jump and ack in the same cycle: the acked data is dropped (wrong path), no DISCARD, and the next request uses the target.
- Arithmetic: pc+4 is 32-bit and wraps modulo 2^32 (32'hFFFF_FFFC -> 0).

## Timing
- Fetch latency: ack at edge N gives `inst_valid_out` from N+1.
- A zero-wait memory (ack in the request cycle) sustains 1 instruction/cycle.
- `flush_out` and `stall_out` are combinational from the execute inputs. All other outputs are registered.
- Jump to first target request: the request appears in the cycle after the jump, or after the discard ack.
- Reset mid-transaction: the transaction is abandoned at once. Late acks are ignored in BOOT.

## Configuration
- Macro `CORE_PC_CTRL_MISALIGN_TRAP_EN`.
- Defined: a jump with target[1:0] != 0 sets pc <= TRAP_ADDR and pulses `misalign_out` for one cycle (registered). Flush behaves as for a normal jump.
- Undefined: the target is forced to {target[31:2], 2'b00}, and `misalign_out` is tied to 0.

## Structure
- Shared defines in `defines.v`:
  - `CPURstAddress`, `HoldEnable`/`HoldNone`, `JumpEnable`/`JumpDisable`.
  - `InstAddressBus`, `InstByteBus`.
  - New state encodings `PCState_BOOT`/`FETCH`/`HOLD`/`DISCARD`.
- One sub-module, `core_pc_skid`: a one-entry instruction+address buffer with load, drain and clear.

## Test plan
- Release reset with a zero-wait memory -> requests to 0x0, 0x4, 0x8; `inst_valid_out` is high from the cycle after the first ack, with `inst_addr_out` = 0x0, 0x4, 0x8.
- Memory with 3-cycle ack latency; jump to 0x40 one cycle after a request to 0x10 -> `flush_out` is high that cycle; the 0x10 data is never presented; next request is 0x40.
- Hold asserted in the cycle an ack for 0x20 arrives, for 4 cycles -> no request and `inst_valid_out` = 0 during the hold; 0x20 is presented at the release edge; the request for 0x24 is issued the same cycle.
- Jump plus hold simultaneously, with the skid buffer full -> buffer cleared, flush pulse, next request = jump target.
- pc = 0xFFFF_FFFC fetched -> next request address 0x0.
- Jump to 0x102 -> with the macro: `misalign_out` pulses and the next request is 0x100 (TRAP_ADDR). Without the macro: the next request is 0x100 and `misalign_out` stays 0.
